// File: rtl/aes256_dec_core.sv
// aes256_dec_core: iterative AES inverse cipher (FIPS-197) for 10/12/14 rounds.
// The ciphertext is written as four 32-bit words, and a control write starts the run.
// Round keys are requested by index on key_addr and must arrive combinationally on key_data.
// Byte k of every 128-bit quantity sits at bits [8k+7:8k]. Byte k is row k%4, column k/4.
module aes256_dec_core #(
  parameter int NR = 14
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ctrl_dataIn,
  input  logic             addr,
  input  logic [31:0]      inpAES,
  input  logic [127:0]     key_data,
  output logic [3:0]       key_addr,
  output logic [15:0][7:0] outAES,
  output logic             ctrl_dataOut,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARK0   = 3'd1,
    ISHIFT = 3'd2,
    ISUB   = 3'd3,
    ARK    = 3'd4,
    IMIX   = 3'd5,
    DONE   = 3'd6
  } fsm_t;

  // Inverse S-box, entry x at index x.
  localparam logic [0:255][7:0] INV_SBOX = {
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Multiply by x in GF(2^8) with reduction polynomial 0x11B.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant (only 09, 0b, 0d, 0e are used).
  function automatic logic [7:0] gmul_k(input logic [7:0] x, input logic [3:0] k);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xt(x);
    x4 = xt(x2);
    x8 = xt(x4);
    return (k[0] ? x : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

  fsm_t             fsm_reg;
  logic [7:0]       ctrl_reg;
  logic [1:0]       w_reg;
  logic [3:0]       rnd_reg;
  logic [3:0]       sub_cnt_reg;
  logic [15:0][7:0] blk_reg;
  logic [15:0][7:0] out_reg;
  logic             done_reg;

  logic [15:0][7:0] ark_blk;
  logic [15:0][7:0] shift_blk;
  logic [15:0][7:0] mix_blk;
  logic [7:0]       sub_out;

  // Only bit 0 of the control register (start) has a function; the rest are reserved.
  logic unused_ctrl_bits;
  assign unused_ctrl_bits = |ctrl_reg[7:1];

  // AddRoundKey: key byte k lines up with state byte k.
  assign ark_blk = blk_reg ^ key_data;

  // One S-box lookup per cycle, walking the bytes in index order.
  assign sub_out = INV_SBOX[blk_reg[sub_cnt_reg]];

  // InvShiftRows: row r rotates right by r columns.
  for (genvar gi = 0; gi < 16; gi++) begin : g_shift
    localparam int ROW = gi % 4;
    localparam int COL = gi / 4;
    localparam int SRC = ROW + 4 * ((COL - ROW + 4) % 4);
    assign shift_blk[gi] = blk_reg[SRC];
  end

  // InvMixColumns: each output row is 0e,0b,0d,09 applied starting at its own row.
  for (genvar gi = 0; gi < 4; gi++) begin : g_mix_col
    for (genvar gj = 0; gj < 4; gj++) begin : g_mix_row
      assign mix_blk[4*gi+gj] = gmul_k(blk_reg[4*gi+gj],           4'he)
                              ^ gmul_k(blk_reg[4*gi+((gj+1)%4)],   4'hb)
                              ^ gmul_k(blk_reg[4*gi+((gj+2)%4)],   4'hd)
                              ^ gmul_k(blk_reg[4*gi+((gj+3)%4)],   4'h9);
    end
  end

  assign key_addr     = (fsm_reg == IDLE) ? 4'd0 : rnd_reg;
  assign busy         = (fsm_reg != IDLE);
  assign outAES       = out_reg;
  assign ctrl_dataOut = done_reg;

  // Host writes, round sequencing and the state datapath, all in one sequencer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fsm_reg     <= IDLE;
      ctrl_reg    <= 8'h00;
      w_reg       <= 2'd0;
      rnd_reg     <= 4'd0;
      sub_cnt_reg <= 4'd0;
      blk_reg     <= '0;
      out_reg     <= '0;
      done_reg    <= 1'b0;
    end else begin
      case (fsm_reg)
        IDLE: begin
          if (ctrl_dataIn) begin
            if (addr) begin
              blk_reg[{w_reg, 2'b00} +: 4] <= inpAES;
              w_reg                        <= w_reg + 2'd1;
            end else begin
              ctrl_reg <= inpAES[7:0];
              w_reg    <= 2'd0;
            end
          end
          if (ctrl_reg[0]) begin
            fsm_reg <= ARK0;
            rnd_reg <= 4'(NR);
          end
        end
        ARK0: begin
          blk_reg <= ark_blk;
          rnd_reg <= rnd_reg - 4'd1;
          fsm_reg <= ISHIFT;
        end
        ISHIFT: begin
          blk_reg     <= shift_blk;
          sub_cnt_reg <= 4'd0;
          fsm_reg     <= ISUB;
        end
        ISUB: begin
          blk_reg[sub_cnt_reg] <= sub_out;
          sub_cnt_reg          <= sub_cnt_reg + 4'd1;
          if (sub_cnt_reg == 4'd15) begin
            fsm_reg <= ARK;
          end
        end
        ARK: begin
          blk_reg <= ark_blk;
          if (rnd_reg == 4'd0) begin
            // Result and valid are registered together so they appear in DONE.
            out_reg  <= ark_blk;
            done_reg <= 1'b1;
            fsm_reg  <= DONE;
          end else begin
            fsm_reg <= IMIX;
          end
        end
        IMIX: begin
          blk_reg <= mix_blk;
          rnd_reg <= rnd_reg - 4'd1;
          fsm_reg <= ISHIFT;
        end
        DONE: begin
          // Dropping the start bit here forces a fresh start write for the next run.
          done_reg <= 1'b0;
          ctrl_reg <= 8'h00;
          w_reg    <= 2'd0;
          fsm_reg  <= IDLE;
        end
        default: begin
          fsm_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes256_dec_core.sv
// tb_aes256_dec_core: scoreboard bench for aes256_dec_core (NR=14 and NR=10 instances).
// Round keys come from a key expansion built on an S-box derived arithmetically here.
module tb_aes256_dec_core;

  localparam logic [127:0] PLAIN = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             resetn;
  logic             wr;
  logic             sel;
  logic             addr_s;
  logic [31:0]      wdata;
  logic [127:0]     kd14;
  logic [127:0]     kd10;
  logic [3:0]       ka14;
  logic [3:0]       ka10;
  logic [15:0][7:0] out14;
  logic [15:0][7:0] out10;
  logic             dv14;
  logic             dv10;
  logic             busy14;
  logic             busy10;

  logic [127:0] rk14 [16];
  logic [127:0] rk10 [16];
  logic [31:0]  ws [64];
  logic [7:0]   sbox [256];

  assign kd14 = rk14[ka14];
  assign kd10 = rk10[ka10];

  aes256_dec_core #(.NR(14)) dut14 (
    .clk(clk), .resetn(resetn), .ctrl_dataIn(wr & ~sel), .addr(addr_s), .inpAES(wdata),
    .key_data(kd14), .key_addr(ka14), .outAES(out14), .ctrl_dataOut(dv14), .busy(busy14)
  );

  aes256_dec_core #(.NR(10)) dut10 (
    .clk(clk), .resetn(resetn), .ctrl_dataIn(wr & sel), .addr(addr_s), .inpAES(wdata),
    .key_data(kd10), .key_addr(ka10), .outAES(out10), .ctrl_dataOut(dv10), .busy(busy10)
  );

  typedef struct {
    logic         s;
    logic [127:0] data;
    int           due;
    string        name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   hist [16];
  logic hist_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference helpers ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] l;
    logic [7:0] r;
    l = b << n;
    r = b >> (8 - n);
    return l | r;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
  endfunction

  // FIPS byte string (byte 0 leftmost) to bus order (byte 0 in the low bits).
  function automatic logic [127:0] fips2bus(input logic [127:0] f);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = f[127 - 8*k -: 8];
    return r;
  endfunction

  function automatic logic [127:0] pack_rk(input int rd);
    logic [127:0] v;
    for (int k = 0; k < 16; k++) v[8*k +: 8] = ws[4*rd + k/4][31 - 8*(k%4) -: 8];
    return v;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic       found;
    for (int x = 0; x < 256; x++) begin
      inv   = 8'h00;
      found = 1'b0;
      for (int y = 1; y < 256 && !found && x != 0; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) begin
          inv   = 8'(y);
          found = 1'b1;
        end
      end
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) ws[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = ws[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      ws[i] = ws[i-nk] ^ t;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic mon_one(input logic s, input logic [127:0] data);
    exp_t e;
    if (q.size() == 0 || q[0].s != s) begin
      checks++;
      errors++;
      $display("FAIL unexpected_output dut_nr=%0d actual=%h required=no_output", s ? 10 : 14, data);
    end else begin
      e = q.pop_front();
      chk({e.name, "_plain"}, data, e.data);
      checks++;
      if (cyc != e.due) begin
        errors++;
        $display("FAIL %s_latency actual_cycle=%0d required_cycle=%0d", e.name, cyc, e.due);
      end else begin
        $display("txn %s: out=%h at cycle %0d", e.name, data, cyc);
      end
    end
  endtask

  // Monitor: compares every result pulse with the head of the scoreboard.
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (dv14) mon_one(1'b0, out14);
      if (dv10) mon_one(1'b1, out10);
      if (hist_en && busy14) hist[ka14] <= hist[ka14] + 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wr_word(input logic s, input logic a, input logic [31:0] d);
    @(negedge clk);
    sel    = s;
    addr_s = a;
    wdata  = d;
    wr     = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic load(input logic s, input logic [127:0] ct);
    logic [127:0] b;
    b = fips2bus(ct);
    for (int w = 0; w < 4; w++) wr_word(s, 1'b1, b[32*w +: 32]);
  endtask

  task automatic start(input logic s, input logic exp_out, input string name);
    exp_t e;
    @(negedge clk);
    sel    = s;
    addr_s = 1'b0;
    wdata  = 32'h0000_0001;
    wr     = 1'b1;
    if (exp_out) begin
      e.s    = s;
      e.data = fips2bus(PLAIN);
      e.due  = cyc + 2 + 19 * (s ? 10 : 14);
      e.name = name;
      q.push_back(e);
    end
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout actual=no_result required=result_within_400_cycles", name);
      q.delete();
    end
  endtask

  task automatic post_idle(input logic s, input string name);
    @(negedge clk);
    chk({name, "_busy_after"}, s ? busy10 : busy14, 0);
    chk({name, "_keyaddr_idle"}, s ? ka10 : ka14, 0);
    repeat (5) @(negedge clk);
    chk({name, "_no_restart"}, s ? busy10 : busy14, 0);
    chk({name, "_valid_low"}, s ? dv10 : dv14, 0);
  endtask

  initial begin
    logic [127:0] b;
    resetn = 1'b0;
    wr     = 1'b0;
    sel    = 1'b0;
    addr_s = 1'b0;
    wdata  = 32'h0;
    for (int i = 0; i < 16; i++) begin
      hist[i] = 0;
      rk14[i] = '0;
      rk10[i] = '0;
    end
    build_sbox();
    expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
    for (int r = 0; r <= 14; r++) rk14[r] = pack_rk(r);
    expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
    for (int r = 0; r <= 10; r++) rk10[r] = pack_rk(r);

    repeat (3) @(negedge clk);
    chk("rst_busy14", busy14, 0);
    chk("rst_out14", out14, 0);
    chk("rst_keyaddr14", ka14, 0);
    chk("rst_valid14", dv14, 0);
    chk("rst_busy10", busy10, 0);
    chk("rst_out10", out10, 0);
    chk("rst_keyaddr10", ka10, 0);
    chk("rst_valid10", dv10, 0);
    @(negedge clk);
    resetn = 1'b1;

    // FIPS-197 C.3 with key_addr histogram
    load(1'b0, CT_C3);
    hist_en = 1'b1;
    start(1'b0, 1'b1, "c3");
    wait_done("c3");
    post_idle(1'b0, "c3");
    hist_en = 1'b0;
    for (int v = 0; v < 15; v++) begin
      checks++;
      if (hist[v] != ((v == 14) ? 1 : 19)) begin
        errors++;
        $display("FAIL keyaddr_dwell_%0d actual=%0d required=%0d", v, hist[v], (v == 14) ? 1 : 19);
      end
    end
    checks++;
    if (hist[15] != 0) begin
      errors++;
      $display("FAIL keyaddr_dwell_15 actual=%0d required=0", hist[15]);
    end

    // FIPS-197 C.1 on the 10-round instance
    load(1'b1, CT_C1);
    start(1'b1, 1'b1, "c1");
    wait_done("c1");
    post_idle(1'b1, "c1");

    // Writes while busy must be ignored
    load(1'b0, CT_C3);
    start(1'b0, 1'b1, "busy_wr");
    repeat (20) @(negedge clk);
    wr_word(1'b0, 1'b1, 32'hffff_ffff);
    wr_word(1'b0, 1'b0, 32'h0000_0001);
    wait_done("busy_wr");
    post_idle(1'b0, "busy_wr");

    // Word counter wrap: fifth write replaces a bad word 0
    b = fips2bus(CT_C3);
    wr_word(1'b0, 1'b1, 32'hdead_beef);
    wr_word(1'b0, 1'b1, b[63:32]);
    wr_word(1'b0, 1'b1, b[95:64]);
    wr_word(1'b0, 1'b1, b[127:96]);
    wr_word(1'b0, 1'b1, b[31:0]);
    start(1'b0, 1'b1, "wrap");
    wait_done("wrap");
    post_idle(1'b0, "wrap");

    // Reset in the middle of a run
    load(1'b0, CT_C3);
    start(1'b0, 1'b0, "abort");
    repeat (99) @(negedge clk);
    chk("midrun_busy_before_reset", busy14, 1);
    resetn = 1'b0;
    #1;
    chk("midrun_rst_busy", busy14, 0);
    chk("midrun_rst_out", out14, 0);
    chk("midrun_rst_keyaddr", ka14, 0);
    chk("midrun_rst_valid", dv14, 0);
    @(negedge clk);
    resetn = 1'b1;
    load(1'b0, CT_C3);
    start(1'b0, 1'b1, "after_rst");
    wait_done("after_rst");
    post_idle(1'b0, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=still_running required=finished");
    $fatal(1);
  end

endmodule
